load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage of the multicycle RV32I core, downstream of the control unit. It accepts a load or store request during the control unit's execute state and performs one single-beat transaction on the data bus using a valid/ready handshake. It holds the core in `stall` until the transaction completes, then presents the byte-lane-aligned, sign- or zero-extended load result for writeback. Misaligned or illegal accesses are rejected without touching the bus.

## Interface
- `ADDR_W`, 32: byte address width.
- `XLEN`, 32: data width. Only 32 is supported.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `issue`  in  1  high while the control unit is in execute.
- `load_req`  in  1  current instruction is a load.
- `store_req`  in  1  current instruction is a store.
- `f3`  in  3  funct3; selects width and signedness.
- `addr`  in  ADDR_W  effective byte address from the ALU.
- `store_data`  in  XLEN  rs2 value.
- `stall`  out  1  hold the control unit.
- `load_data`  out  XLEN  extended load result.
- `access_err`  out  1  misaligned or illegal access, pulsed in DONE.
- `mem_valid`  out  1  bus request valid.
- `mem_we`  out  1  write strobe, qualified by `mem_valid`.
- `mem_addr`  out  ADDR_W  word-aligned address (`addr[1:0]` = 0).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_ready`  in  1  slave accepts or completes the beat.
- `mem_rdata`  in  XLEN  read data, valid when `mem_valid && mem_ready` with `mem_we`=0.

## Operation
- States: IDLE, REQ, DONE.
- Accept condition: IDLE, `issue` high, and exactly one of `load_req`/`store_req` high.
  - On accept, latch `f3`, `addr`, `store_data` and the direction.
  - If the access is valid, go to REQ. Otherwise go directly to DONE with the error flag set.
- Valid `f3` values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. No split accesses.
- Both `load_req` and `store_req` high together is illegal.
- Byte enables:
  - SB/LB/LBU: `mem_be` = 1<<`addr[1:0]`.
  - SH/LH/LHU: `mem_be` = 4'b0011 if `addr[1]`=0, else 4'b1100.
  - SW/LW: `mem_be` = 4'b1111.
- Store data: SB replicates `store_data[7:0]` ×4; SH replicates `[15:0]` ×2; SW passes through.
- Load data: select the lane by `addr[1:0]`, then sign-extend for LB/LH or zero-extend for LBU/LHU. Capture into the `load_data` register on the completing beat.
- REQ:
  - `mem_valid` is high and all `mem_*` outputs are held stable until `mem_ready`.
  - On `mem_valid && mem_ready`, go to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - `issue` is ignored in DONE.
  - `access_err` is high for that cycle on error, and `load_data` is 0 on error.
- `load_data` holds its value until the next completed load or error.
- `stall` = (IDLE && `issue` && (`load_req`||`store_req`)) || REQ. It is combinational from `issue`, because the control unit samples it in the same cycle.

## Timing
- Reset values: state IDLE; `mem_valid`, `mem_we`, `mem_be`, `access_err` = 0; `mem_addr`, `mem_wdata`, `load_data` = 0; `stall` reflects inputs only.
- Asserting reset mid-REQ drops `mem_valid` immediately, and the transaction is abandoned.
- Accept at cycle t:
  - `mem_valid` is registered and rises at t+1.
  - If `mem_ready` is high at t+1, DONE is at t+2 and `stall` is low at t+2.
  - Minimum stall is 2 cycles; each wait state adds 1.
- Error path: accept at t, DONE at t+1; stall is 1 cycle.
- `mem_ready` is ignored outside REQ.
- `load_data` is valid from the DONE cycle onward, ahead of writeback.

## Structure
- Types package additions:
  - `lsu_state_t` (IDLE/REQ/DONE).
  - `mem_width_t` enum (BYTE, HALF, WORD).
  - Localparams for the load/store `f3` codes.
- One combinational sub-module, `lsu_lane_align`, shared by both directions:
  - Store side: `mem_be` and `mem_wdata` from (width, `addr[1:0]`, `store_data`).
  - Load side: extended data from (width, signed, `addr[1:0]`, `mem_rdata`).

## Test plan
- LW, `addr`=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` high on first REQ cycle -> `mem_addr`=0x100, `mem_be`=1111, `stall` high for 2 cycles, `load_data`=0xDEADBEEF.
- LB and LBU at `addr`=0x103, `mem_rdata`=0x80FF0000 -> `mem_be`=1000; `load_data`=0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH at `addr`=0x202, `store_data`=0x1234ABCD, `mem_ready` delayed 3 cycles -> `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD held stable, `stall` high for 5 cycles.
- LW at `addr`=0x101 -> `mem_valid` never rises, `access_err` pulses 1 cycle, `load_data`=0, `stall` high 1 cycle.
- Both `load_req` and `store_req` high, and separately load `f3`=011 -> `access_err` pulses, no bus activity.
- `rst` low while in REQ with `mem_ready` low -> `mem_valid`=0 immediately, state IDLE, next LW completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit types and helpers
// shared by the LSU, its lane aligner and the bus interface users
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    W_BYTE,
    W_HALF,
    W_WORD
  } mem_width_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic mem_width_t f3_width(logic [2:0] f3);
    mem_width_t w;
    unique case (f3[1:0])
      2'b00:   w = W_BYTE;
      2'b01:   w = W_HALF;
      default: w = W_WORD;
    endcase
    return w;
  endfunction

  // illegal funct3 for the direction, or not naturally aligned
  function automatic logic acc_illegal(
    logic       st,
    logic [2:0] f3,
    logic [1:0] off
  );
    logic bad_f3;
    logic mis;
    if (st) begin
      bad_f3 = !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
    end else begin
      bad_f3 = !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                 f3 == F3_LBU || f3 == F3_LHU);
    end
    mis = (f3[1:0] == 2'b01 && off[0]) ||
          (f3[1:0] == 2'b10 && off != 2'b00);
    return bad_f3 | mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// single-beat valid/ready data bus
// master = LSU, slave = data memory
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ready;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: byte-lane steering for both directions
// store: enables + replicated data; load: lane pick + extension
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  mem_width_t  width_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // lane select, then width-dependent steering and extension
  always_comb begin
    lane_b  = rdata_i[{off_i, 3'b000} +: 8];
    lane_h  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o    = 4'b1111;
    wdata_o = sdata_i;
    ldata_o = rdata_i;
    unique case (width_i)
      W_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = {{24{sign_i & lane_b[7]}}, lane_b};
      end
      W_HALF: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
        ldata_o = {{16{sign_i & lane_h[15]}}, lane_h};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = sdata_i;
        ldata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access stage
// one single-beat bus transaction per accepted request
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [2:0]        f3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              stall,
  output logic [XLEN-1:0]   load_data,
  output logic              access_err,
  load_store_unit_if.master mem
);

  lsu_state_t        state_q, state_d;
  logic              st_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   sdata_q;
  logic              err_q;
  logic [XLEN-1:0]   ld_q;

  logic        req_any;
  logic        accept;
  logic        bad;
  logic        in_req;
  logic        beat;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ldata;

  assign req_any = load_req | store_req;
  assign accept  = (state_q == S_IDLE) & issue & req_any;
  assign bad     = (load_req & store_req) |
                   acc_illegal(store_req, f3, addr[1:0]);
  assign in_req  = (state_q == S_REQ);
  assign beat    = in_req & mem.mem_ready;

  lsu_lane_align u_align (
    .width_i (f3_width(f3_q)),
    .sign_i  (~f3_q[2]),
    .off_i   (addr_q[1:0]),
    .sdata_i (sdata_q),
    .rdata_i (mem.mem_rdata),
    .be_o    (be),
    .wdata_o (wdata),
    .ldata_o (ldata)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next state: IDLE -> REQ|DONE -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = bad ? S_DONE : S_REQ;
      S_REQ:  if (mem.mem_ready) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // request latch and load result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
    end else if (accept) begin
      st_q    <= store_req;
      f3_q    <= f3;
      addr_q  <= addr;
      sdata_q <= store_data;
      err_q   <= bad;
      if (bad) ld_q <= '0;
    end else if (beat && !st_q) begin
      ld_q <= ldata;
    end
  end

  assign stall         = accept | in_req;
  assign load_data     = ld_q;
  assign access_err    = (state_q == S_DONE) & err_q;
  assign mem.mem_valid = in_req;
  assign mem.mem_we    = in_req & st_q;
  assign mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_be    = in_req ? be : 4'b0000;
  assign mem.mem_wdata = wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized bench with a transaction-level model
// compare process checks the DUT against per-cycle expectations
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue;
  logic        load_req;
  logic        store_req;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        access_err;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .load_req   (load_req),
    .store_req  (store_req),
    .f3         (f3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .access_err (access_err),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_valid, e_we, e_err, e_wchk;
  logic [31:0] e_addr, e_wdata, e_ld;
  logic [3:0]  e_be;
  logic [31:0] prev_ld;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int m_size(logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_err(bit ld, bit st, logic [2:0] f, logic [31:0] a);
    bit legal;
    if (ld && st) return 1'b1;
    legal = st ? (f < 3) : (f != 3 && f < 6);
    if (!legal) return 1'b1;
    return (a % m_size(f)) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f, logic [31:0] a);
    return 4'(((1 << m_size(f)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f, logic [31:0] sd);
    if (m_size(f) == 1) return {4{sd[7:0]}};
    if (m_size(f) == 2) return {2{sd[15:0]}};
    return sd;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a,
                                         logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (m_size(f) == 1)
      return f[2] ? (v & 32'hFF) : 32'($signed(v[7:0]));
    if (m_size(f) == 2)
      return f[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
    return v;
  endfunction

  // per-cycle compare against the current expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("mem_valid", 32'(bus.mem_valid), 32'(e_valid));
      check("access_err", 32'(access_err), 32'(e_err));
      check("load_data", load_data, e_ld);
      if (e_valid) begin
        check("mem_we", 32'(bus.mem_we), 32'(e_we));
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_be", 32'(bus.mem_be), 32'(e_be));
        if (e_wchk) check("mem_wdata", bus.mem_wdata, e_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    issue     = 1'b0;
    load_req  = 1'b0;
    store_req = 1'b0;
    e_stall   = 1'b0;
    e_valid   = 1'b0;
    e_err     = 1'b0;
    e_wchk    = 1'b0;
    e_ld      = prev_ld;
  endtask

  task automatic do_txn(bit ld, bit st, logic [2:0] f, logic [31:0] a,
                        logic [31:0] sd, logic [31:0] rd, int waits,
                        bit hold_issue);
    bit er;
    er = m_err(ld, st, f, a);
    issue         = 1'b1;
    load_req      = ld;
    store_req     = st;
    f3            = f;
    addr          = a;
    store_data    = sd;
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
    e_stall = ld | st;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_wchk  = 1'b0;
    e_ld    = prev_ld;
    step();
    if (!(ld | st)) begin
      set_idle();
      return;
    end
    if (!er) begin
      for (int k = 0; k <= waits; k++) begin
        load_req      = 1'($urandom);
        store_req     = 1'($urandom);
        f3            = 3'($urandom);
        addr          = $urandom;
        store_data    = $urandom;
        bus.mem_ready = (k == waits);
        bus.mem_rdata = (k == waits) ? rd : $urandom;
        e_stall = 1'b1;
        e_valid = 1'b1;
        e_we    = st;
        e_addr  = a & 32'hFFFF_FFFC;
        e_be    = m_be(f, a);
        e_wchk  = st;
        e_wdata = m_wdata(f, sd);
        step();
      end
    end
    if (er) prev_ld = 32'h0;
    else if (ld) prev_ld = m_load(f, a, rd);
    issue         = hold_issue;
    load_req      = hold_issue;
    store_req     = 1'b0;
    f3            = 3'b010;
    addr          = 32'h0;
    bus.mem_ready = 1'($urandom);
    e_stall = 1'b0;
    e_valid = 1'b0;
    e_err   = er;
    e_wchk  = 1'b0;
    e_ld    = prev_ld;
    step();
    set_idle();
  endtask

  initial begin
    rst           = 1'b0;
    prev_ld       = 32'h0;
    f3            = 3'b0;
    addr          = 32'h0;
    store_data    = 32'h0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    set_idle();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    issue    = 1'b1;
    load_req = 1'b1;
    e_stall  = 1'b1;
    #1;
    check("rst_stall_comb", 32'(stall), 32'h1);
    set_idle();
    step();
    rst = 1'b1;
    step();

    check("model_lb", m_load(3'b000, 32'h103, 32'h80FF0000), 32'hFFFFFF80);
    check("model_lbu", m_load(3'b100, 32'h103, 32'h80FF0000), 32'h00000080);
    check("model_sh_be", 32'(m_be(3'b001, 32'h202)), 32'hC);
    check("model_sh_wd", m_wdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    check("model_lw_mis", 32'(m_err(1, 0, 3'b010, 32'h101)), 32'h1);

    do_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    check("lw_result", load_data, 32'hDEADBEEF);
    do_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 1);
    check("lb_result", load_data, 32'hFFFFFF80);
    do_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
    check("lbu_result", load_data, 32'h00000080);
    do_txn(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0);
    check("sh_keeps_ld", load_data, 32'h00000080);
    do_txn(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    check("lw_mis_ld", load_data, 32'h0);
    do_txn(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);
    do_txn(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1);
    do_txn(0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);

    // reset while waiting in REQ
    issue     = 1'b1;
    load_req  = 1'b1;
    f3        = 3'b010;
    addr      = 32'h300;
    e_stall   = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    e_valid = 1'b1;
    e_we    = 1'b0;
    e_addr  = 32'h300;
    e_be    = 4'hF;
    step();
    rst     = 1'b0;
    prev_ld = 32'h0;
    set_idle();
    step();
    rst = 1'b1;
    step();
    do_txn(1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0, 0);
    check("post_rst_lw", load_data, 32'hCAFEF00D);

    for (int n = 0; n < 300; n++) begin
      int          r;
      bit          ld, st;
      logic [2:0]  f;
      logic [31:0] a;
      r = int'($urandom_range(0, 19));
      ld = 1'b0;
      st = 1'b0;
      if (r == 0) begin
        ld = 1'b1;
        st = 1'b1;
      end else if (r < 10) begin
        ld = 1'b1;
      end else if (r < 19) begin
        st = 1'b1;
      end
      f = 3'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        f = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
        if (ld && $urandom_range(0, 1) == 1 && f != 3'b010) f[2] = 1'b1;
      end
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      do_txn(ld, st, f, a, $urandom, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        bus.mem_ready = 1'($urandom);
        step();
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
